uart_tx_slave: RTL

Bus-attached UART transmitter that consumes the character stream the boot program writes to the 0x0003_0000 peripheral window. It sits downstream of the CPU data port on `naive_bus` as a slave. Written bytes go into a small FIFO and are serialized 8N1, LSB first, on `uart_tx`. Reads return a status word so software can poll for space and for transmit-idle.

---
 rtl/uart_tx_slave.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/uart_tx_slave.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_slave
//  Purpose  : Bus slave UART transmitter. Bus writes push wr_data[7:0] into a
//             small FIFO. An FSM sends each byte 8N1, LSB first, on uart_tx.
//             Bus reads return a registered status word.
//  Option   : UART_TX_DROP_ON_FULL_EN. When defined, writes are always
//             granted. A write to a full FIFO is dropped and sets a sticky
//             overflow flag, which is status[3].
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx_slave #(
    parameter int CLK_DIV    = 434,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rd_req,
    output logic        rd_gnt,
    input  logic [31:0] rd_addr,
    output logic [31:0] rd_data,
    input  logic        wr_req,
    output logic        wr_gnt,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data,
    output logic        uart_tx
);

    localparam int              AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]     DEPTH_C  = (AW+1)'(FIFO_DEPTH);
    localparam logic [15:0]     BAUD_MAX = 16'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;
    logic [7:0]      shift;
    logic [2:0]      bit_cnt;
    logic [15:0]     baud_cnt;
    logic            full, empty, push, pop, bit_end, ovf_bit;
    logic [31:0]     status;

    // The address is decoded upstream and the upper data bits carry nothing
    logic            unused_bits;
    assign unused_bits = ^{rd_addr, wr_addr, wr_data[31:8]};

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign bit_end = (baud_cnt == BAUD_MAX);
    assign rd_gnt  = rd_req;
    // Grant and push both use the registered full flag. A pop in the same
    // cycle does not open a slot early.
    assign push    = wr_req && !full;

`ifdef UART_TX_DROP_ON_FULL_EN
    logic overflow;
    assign wr_gnt  = wr_req;
    assign ovf_bit = overflow;

    // Sticky overflow: a drop sets it, a status read clears it, and a drop wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            overflow <= 1'b0;
        else if (wr_req && full)
            overflow <= 1'b1;
        else if (rd_req)
            overflow <= 1'b0;
    end
`else
    assign wr_gnt  = wr_req && !full;
    assign ovf_bit = 1'b0;
`endif

    // FIFO storage. It needs no reset because count qualifies every entry.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wr_data[7:0];
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // TX state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // TX next state, and the pop request raised while IDLE
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = S_START;
                end
            end
            S_START: if (bit_end) state_nxt = S_DATA;
            S_DATA:  if (bit_end && bit_cnt == 3'd7) state_nxt = S_STOP;
            S_STOP:  if (bit_end) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Baud counter, bit counter and shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift    <= 8'h00;
            bit_cnt  <= 3'd0;
            baud_cnt <= 16'd0;
        end else if (state == S_IDLE) begin
            baud_cnt <= 16'd0;
            bit_cnt  <= 3'd0;
            if (pop)
                shift <= mem[rd_ptr];
        end else begin
            baud_cnt <= bit_end ? 16'd0 : baud_cnt + 16'd1;
            if (state == S_DATA && bit_end) begin
                shift   <= {1'b0, shift[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end

    // The line level comes from the state register, so reset drives it high at once
    always_comb begin
        uart_tx = 1'b1;
        case (state)
            S_START: uart_tx = 1'b0;
            S_DATA:  uart_tx = shift[0];
            default: uart_tx = 1'b1;
        endcase
    end

    assign status = {16'h0000, 8'(count), 4'h0, ovf_bit, empty, full,
                     (state != S_IDLE)};

    // Registered read data: the status word from the request cycle, otherwise zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rd_data <= 32'h0;
        else
            rd_data <= rd_req ? status : 32'h0;
    end

endmodule
`default_nettype wire
